// File: rtl/portal_ind_pkg.sv
// ============================================================================
// Module  : portal_ind_pkg
// Purpose : Register offsets, FSM states and STATUS bit positions shared by
//           the indication-portal MMIO block and its per-channel logic.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package portal_ind_pkg;

  localparam int unsigned REG_STATUS    = 32'h000;
  localparam int unsigned REG_CHANNEL   = 32'h004;
  localparam int unsigned REG_INTR_EN   = 32'h008;
  localparam int unsigned REG_UF_CLR    = 32'h00C;
  localparam int unsigned REG_MSG_SEL   = 32'h010;
  localparam int unsigned REG_MSG_SIZE  = 32'h014;
  localparam int unsigned REG_CNT0      = 32'h020;
  localparam int unsigned REG_CNT1      = 32'h024;
  localparam int unsigned REG_IND0      = 32'h100;
  localparam int unsigned REG_IND1      = 32'h200;

  localparam logic [31:0] CHANNEL_NONE  = 32'hFFFF_FFFF;

  localparam int STATUS_ANY_BIT       = 0;
  localparam int STATUS_IND0_BIT      = 1;
  localparam int STATUS_IND1_BIT      = 2;
  localparam int STATUS_UNDERFLOW_BIT = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/portal_ind_chan.sv
// ============================================================================
// Module  : portal_ind_chan
// Purpose : One indication channel: pop strobe, sticky underflow flag and,
//           with PORTAL_IND_MMIO_STATS_EN, a wrapping 16-bit pop counter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module portal_ind_chan
  import portal_ind_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        pop_req,
  input  logic        not_empty,
  input  logic        underflow_clr,
  output logic        deq,
  output logic        underflow
`ifdef PORTAL_IND_MMIO_STATS_EN
  ,
  input  logic        cnt_clr,
  output logic [15:0] pop_cnt
`endif
);

  logic underflow_q, underflow_d;

  assign deq       = pop_req & not_empty;
  assign underflow = underflow_q;

  // A new underflow in the same cycle as a clear must survive the clear.
  always_comb begin
    underflow_d = underflow_q;
    if (underflow_clr)         underflow_d = 1'b0;
    if (pop_req && !not_empty) underflow_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) underflow_q <= 1'b0;
    else        underflow_q <= underflow_d;
  end

`ifdef PORTAL_IND_MMIO_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  assign pop_cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)  cnt_d = 16'h0000;
    else if (deq) cnt_d = cnt_q + 16'h0001;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= 16'h0000;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/portal_ind_mmio.sv
// ============================================================================
// Module  : portal_ind_mmio
// Purpose : MMIO register front-end for two indication FIFOs with status,
//           interrupt and message-size lookup. Optional pop counters are
//           enabled by defining PORTAL_IND_MMIO_STATS_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module portal_ind_mmio
  import portal_ind_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int NUM_CH = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  input  logic [31:0]       ind0_first,
  input  logic              ind0_not_empty,
  output logic              ind0_deq,
  input  logic [31:0]       ind1_first,
  input  logic              ind1_not_empty,
  output logic              ind1_deq,
  output logic [15:0]       msg_size_method,
  input  logic [15:0]       msg_size,
  output logic              intr
);

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        intr_en_q, intr_en_d;
  logic [15:0] msg_sel_q, msg_sel_d;
  logic        intr_q, intr_d;

  logic [ADDR_W-1:0] addr_w;
  logic              accept_w, rd_w, wr_w;
  logic [NUM_CH-1:0] ne_w, pop_req_w, deq_w, uf_w;
  logic              uf_clr_w;
  logic [31:0]       status_w, rdata_w;
  logic              unused_w;

  assign addr_w   = {req_addr[ADDR_W-1:2], 2'b00};
  assign accept_w = req_valid & req_ready_q;
  assign rd_w     = accept_w & ~req_write;
  assign wr_w     = accept_w &  req_write;
  assign ne_w     = {ind1_not_empty, ind0_not_empty};
  assign uf_clr_w = wr_w & (addr_w == ADDR_W'(REG_UF_CLR)) & req_wdata[0];
  assign unused_w = ^{req_addr[1:0], req_wdata[31:16]};

  assign pop_req_w[0] = rd_w & (addr_w == ADDR_W'(REG_IND0));
  assign pop_req_w[1] = rd_w & (addr_w == ADDR_W'(REG_IND1));

`ifdef PORTAL_IND_MMIO_STATS_EN
  logic [NUM_CH-1:0] cnt_clr_w;
  logic [15:0]       cnt_w [NUM_CH];
  assign cnt_clr_w[0] = wr_w & (addr_w == ADDR_W'(REG_CNT0));
  assign cnt_clr_w[1] = wr_w & (addr_w == ADDR_W'(REG_CNT1));
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    portal_ind_chan u_chan (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .pop_req       (pop_req_w[i]),
      .not_empty     (ne_w[i]),
      .underflow_clr (uf_clr_w),
      .deq           (deq_w[i]),
      .underflow     (uf_w[i])
`ifdef PORTAL_IND_MMIO_STATS_EN
      ,
      .cnt_clr       (cnt_clr_w[i]),
      .pop_cnt       (cnt_w[i])
`endif
    );
  end

  always_comb begin
    status_w                       = 32'h0;
    status_w[STATUS_ANY_BIT]       = |ne_w;
    status_w[STATUS_IND0_BIT]      = ne_w[0];
    status_w[STATUS_IND1_BIT]      = ne_w[1];
    status_w[STATUS_UNDERFLOW_BIT] = |uf_w;
  end

  always_comb begin
    rdata_w = 32'h0;
    case (addr_w)
      ADDR_W'(REG_STATUS):   rdata_w = status_w;
      ADDR_W'(REG_CHANNEL):  rdata_w = ne_w[0] ? 32'd0 : (ne_w[1] ? 32'd1 : CHANNEL_NONE);
      ADDR_W'(REG_INTR_EN):  rdata_w = {31'h0, intr_en_q};
      ADDR_W'(REG_MSG_SEL):  rdata_w = {16'h0, msg_sel_q};
      ADDR_W'(REG_MSG_SIZE): rdata_w = {16'h0, msg_size};
      ADDR_W'(REG_IND0):     rdata_w = ne_w[0] ? ind0_first : 32'h0;
      ADDR_W'(REG_IND1):     rdata_w = ne_w[1] ? ind1_first : 32'h0;
`ifdef PORTAL_IND_MMIO_STATS_EN
      ADDR_W'(REG_CNT0):     rdata_w = {16'h0, cnt_w[0]};
      ADDR_W'(REG_CNT1):     rdata_w = {16'h0, cnt_w[1]};
`endif
      default:               rdata_w = 32'h0;
    endcase
  end

  // req_ready is registered, so it only rises on the first edge out of reset.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (accept_w) begin
          state_d     = ST_RESP;
          req_ready_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = req_write ? 32'h0 : rdata_w;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    intr_en_d = intr_en_q;
    msg_sel_d = msg_sel_q;
    if (wr_w && addr_w == ADDR_W'(REG_INTR_EN)) intr_en_d = req_wdata[0];
    if (wr_w && addr_w == ADDR_W'(REG_MSG_SEL)) msg_sel_d = req_wdata[15:0];
    intr_d = intr_en_q & (|ne_w);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      intr_en_q   <= 1'b0;
      msg_sel_q   <= 16'h0;
      intr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      intr_en_q   <= intr_en_d;
      msg_sel_q   <= msg_sel_d;
      intr_q      <= intr_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign ind0_deq        = deq_w[0];
  assign ind1_deq        = deq_w[1];
  assign msg_size_method = msg_sel_q;
  assign intr            = intr_q;

endmodule

`default_nettype wire

// File: tb/tb_portal_ind_mmio.sv
// ============================================================================
// Module  : tb_portal_ind_mmio
// Purpose : Directed scoreboard bench for portal_ind_mmio.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_portal_ind_mmio;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid, req_write, rsp_ready;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, rsp_valid;
  logic [31:0] rsp_data;
  logic [31:0] ind0_first, ind1_first;
  logic        ind0_not_empty, ind1_not_empty;
  logic        ind0_deq, ind1_deq;
  logic [15:0] msg_size_method, msg_size;
  logic        intr;

  int checks = 0;
  int errors = 0;
  int deq0_cnt = 0;
  int deq1_cnt = 0;
  logic [31:0] exp_q[$];

`ifdef PORTAL_IND_MMIO_STATS_EN
  localparam logic [31:0] STATS_EXP = 32'd3;
`else
  localparam logic [31:0] STATS_EXP = 32'd0;
`endif

  always #5 CLK = ~CLK;

  assign msg_size = (msg_size_method == 16'd3) ? 16'd64 : 16'd8;

  portal_ind_mmio #(.ADDR_W(12), .NUM_CH(2)) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .ind0_first      (ind0_first),
    .ind0_not_empty  (ind0_not_empty),
    .ind0_deq        (ind0_deq),
    .ind1_first      (ind1_first),
    .ind1_not_empty  (ind1_not_empty),
    .ind1_deq        (ind1_deq),
    .msg_size_method (msg_size_method),
    .msg_size        (msg_size),
    .intr            (intr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every completed handshake.
  always @(negedge CLK) begin
    #2;
    if (RST_N && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=%h required=none", rsp_data);
      end else begin
        chk("rsp_data", rsp_data, exp_q.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    #2;
    if (ind0_deq) deq0_cnt++;
    if (ind1_deq) deq1_cnt++;
  end

  task automatic wait_accept(input string name);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge CLK);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("rsp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge CLK);
  endtask

  task automatic do_req(input logic wr, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp);
    exp_q.push_back(exp);
    @(negedge CLK);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    wait_accept("req");
    @(negedge CLK);
    req_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b1;
    ind0_first = '0; ind1_first = '0; ind0_not_empty = 1'b0; ind1_not_empty = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_deq", {30'b0, ind1_deq, ind0_deq}, 32'd0);
    chk("rst_intr", {31'b0, intr}, 32'd0);
    chk("rst_msg_method", {16'b0, msg_size_method}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("req_ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Two-word pop from channel 0, then a third for the counter.
    ind0_first = 32'hA5A5_0001; ind0_not_empty = 1'b1;
    do_req(1'b0, 12'h100, 32'h0, 32'hA5A5_0001);
    ind0_first = 32'hA5A5_0002;
    do_req(1'b0, 12'h100, 32'h0, 32'hA5A5_0002);
    chk("deq0_pulses_2", 32'(deq0_cnt), 32'd2);
    ind0_first = 32'hA5A5_0003;
    do_req(1'b0, 12'h100, 32'h0, 32'hA5A5_0003);
    ind0_not_empty = 1'b0;
    chk("deq0_pulses_3", 32'(deq0_cnt), 32'd3);
    do_req(1'b0, 12'h020, 32'h0, STATS_EXP);
    do_req(1'b1, 12'h020, 32'h0, 32'h0);
    do_req(1'b0, 12'h020, 32'h0, 32'h0);

    // Underflow on an empty window, then clear it.
    do_req(1'b0, 12'h200, 32'h0, 32'h0);
    chk("deq1_none_on_empty", 32'(deq1_cnt), 32'd0);
    do_req(1'b0, 12'h000, 32'h0, 32'h8);
    do_req(1'b1, 12'h00C, 32'h1, 32'h0);
    do_req(1'b0, 12'h000, 32'h0, 32'h0);
    do_req(1'b0, 12'h004, 32'h0, 32'hFFFF_FFFF);
    do_req(1'b0, 12'h300, 32'h0, 32'h0);
    do_req(1'b1, 12'h000, 32'hF, 32'h0);
    do_req(1'b0, 12'h000, 32'h0, 32'h0);

    // Interrupt follows channel 1 occupancy.
    do_req(1'b1, 12'h008, 32'h1, 32'h0);
    do_req(1'b0, 12'h008, 32'h0, 32'h1);
    @(negedge CLK);
    chk("intr_idle", {31'b0, intr}, 32'd0);
    ind1_first = 32'h1111_2222; ind1_not_empty = 1'b1;
    @(negedge CLK);
    chk("intr_rise", {31'b0, intr}, 32'd1);
    do_req(1'b0, 12'h004, 32'h0, 32'h1);
    do_req(1'b0, 12'h000, 32'h0, 32'h5);
    do_req(1'b0, 12'h200, 32'h0, 32'h1111_2222);
    ind1_not_empty = 1'b0;
    chk("deq1_pulses_1", 32'(deq1_cnt), 32'd1);
    @(negedge CLK);
    @(negedge CLK);
    chk("intr_fall", {31'b0, intr}, 32'd0);
    ind0_not_empty = 1'b1; ind1_not_empty = 1'b1;
    do_req(1'b0, 12'h004, 32'h0, 32'h0);
    ind0_not_empty = 1'b0; ind1_not_empty = 1'b0;

    // Message size lookup.
    do_req(1'b1, 12'h010, 32'h3, 32'h0);
    chk("msg_size_method", {16'b0, msg_size_method}, 32'd3);
    do_req(1'b0, 12'h014, 32'h0, 32'h40);
    do_req(1'b0, 12'h010, 32'h0, 32'h3);

    // Response back-pressure: the held response must not move.
    @(negedge CLK);
    rsp_ready = 1'b0;
    exp_q.push_back(32'h3);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h010;
    wait_accept("stall1");
    @(negedge CLK);
    req_addr = 12'h014;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
      chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_rsp_data", rsp_data, 32'h3);
      @(negedge CLK);
    end
    exp_q.push_back(32'h40);
    rsp_ready = 1'b1;
    @(negedge CLK);
    wait_accept("stall2");
    @(negedge CLK);
    req_valid = 1'b0;
    wait_drain();

    // Reset while a pop response is pending: response dropped, no replay.
    @(negedge CLK);
    rsp_ready = 1'b0;
    ind0_first = 32'hDEAD_0004; ind0_not_empty = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h100;
    wait_accept("rst_resp");
    @(negedge CLK);
    req_valid = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_rsp_data", rsp_data, 32'd0);
    chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1; rsp_ready = 1'b1; ind0_not_empty = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("deq0_no_replay", 32'(deq0_cnt), 32'd4);
    do_req(1'b0, 12'h008, 32'h0, 32'h0);
    do_req(1'b0, 12'h010, 32'h0, 32'h0);

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
